// File: rtl/map_tile_renderer.sv
// map_tile_renderer: walks the tile map (or a single tile), fetches each tile
// type from map memory with a fixed read latency, and plots the tile as a
// TILE_PX x TILE_PX block with orb glyphs on the VGA plot bus.
module map_tile_renderer #(
    parameter int GRID_W      = 21,
    parameter int GRID_H      = 21,
    parameter int TILE_PX     = 4,
    parameter int X_ORIGIN    = 0,
    parameter int Y_ORIGIN    = 0,
    parameter int MEM_LATENCY = 1,
    parameter int COORD_W     = 5
) (
    input  logic               clock_50,
    input  logic               resetn,
    input  logic               start,
    input  logic               start_tile,
    input  logic [COORD_W-1:0] tile_x,
    input  logic [COORD_W-1:0] tile_y,
    output logic [COORD_W-1:0] map_x,
    output logic [COORD_W-1:0] map_y,
    input  logic [3:0]         map_type,
    output logic               busy,
    output logic               done,
    output logic               vga_plot,
    output logic [7:0]         vga_x,
    output logic [7:0]         vga_y,
    output logic [2:0]         vga_color
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int PX_W  = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;

    localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(MEM_LATENCY - 1);
    localparam logic [PX_W-1:0]    PX_LAST  = PX_W'(TILE_PX - 1);
    localparam logic [PX_W-1:0]    GLYPH_C  = PX_W'(TILE_PX / 2);
    localparam logic [PX_W-1:0]    RING_LO  = PX_W'(1);
    localparam logic [PX_W-1:0]    RING_HI  = PX_W'(TILE_PX - 2);
    localparam logic [COORD_W-1:0] TX_LAST  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] TY_LAST  = COORD_W'(GRID_H - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAW, FIN} state_t;

    state_t state, state_nx;

    logic [COORD_W-1:0] tx, ty;
    logic [LAT_W-1:0]   lat_cnt;
    logic [PX_W-1:0]    px, py;
    logic [3:0]         kind;
    logic               single_tile;

    logic               vld_p1;
    logic [7:0]         x_p1, y_p1;
    logic [2:0]         color_p1;

    logic tile_ok, fetch_last, pix_last, tile_last;

    // Pixel colour for one position inside a tile; orbs collapse to solid
    // fills when the tile is too small to carry a glyph.
    function automatic logic [2:0] glyph_color(input logic [3:0] k,
                                               input logic [PX_W-1:0] px_i,
                                               input logic [PX_W-1:0] py_i);
        logic [2:0] color;
        color = 3'b000;
        case (k)
            4'd3: color = 3'b001;
            4'd4: color = 3'b100;
            4'd2: if (TILE_PX <= 2 || (px_i == GLYPH_C && py_i == GLYPH_C))
                      color = 3'b111;
            4'd1: if (TILE_PX <= 2 ||
                      (px_i >= RING_LO && px_i <= RING_HI &&
                       py_i >= RING_LO && py_i <= RING_HI))
                      color = 3'b111;
            default: color = 3'b000;
        endcase
        return color;
    endfunction

    // Screen coordinate of a pixel, wrapped to the 8-bit VGA range.
    function automatic logic [7:0] screen_coord(input int origin,
                                                input logic [COORD_W-1:0] tile,
                                                input logic [PX_W-1:0] pix);
        return 8'(32'(origin) + 32'(tile) * 32'(TILE_PX) + 32'(pix));
    endfunction

    assign tile_ok    = start_tile &&
                        ({1'b0, tile_x} < (COORD_W+1)'(GRID_W)) &&
                        ({1'b0, tile_y} < (COORD_W+1)'(GRID_H));
    assign fetch_last = (lat_cnt == LAT_LAST);
    assign pix_last   = (px == PX_LAST) && (py == PX_LAST);
    assign tile_last  = (tx == TX_LAST) && (ty == TY_LAST);

    assign map_x     = tx;
    assign map_y     = ty;
    assign vga_plot  = vld_p1;
    assign vga_x     = x_p1;
    assign vga_y     = y_p1;
    assign vga_color = color_p1;

    // State register.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state decode: one fetch/draw pass per tile, FIN after the last tile.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start || tile_ok) state_nx = FETCH;
            FETCH:   if (fetch_last) state_nx = DRAW;
            DRAW:    if (pix_last) state_nx = (single_tile || tile_last) ? FIN : FETCH;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Tile walk, latency counter, pixel scan and registered VGA outputs.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            tx          <= '0;
            ty          <= '0;
            lat_cnt     <= '0;
            px          <= '0;
            py          <= '0;
            kind        <= '0;
            single_tile <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            vld_p1      <= 1'b0;
            x_p1        <= '0;
            y_p1        <= '0;
            color_p1    <= '0;
        end else begin
            vld_p1 <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    lat_cnt <= '0;
                    px      <= '0;
                    py      <= '0;
                    if (start) begin
                        tx          <= '0;
                        ty          <= '0;
                        single_tile <= 1'b0;
                        busy        <= 1'b1;
                    end else if (tile_ok) begin
                        tx          <= tile_x;
                        ty          <= tile_y;
                        single_tile <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                FETCH: begin
                    if (fetch_last) begin
                        lat_cnt <= '0;
                        kind    <= map_type;
                        px      <= '0;
                        py      <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                DRAW: begin
                    vld_p1   <= 1'b1;
                    x_p1     <= screen_coord(X_ORIGIN, tx, px);
                    y_p1     <= screen_coord(Y_ORIGIN, ty, py);
                    color_p1 <= glyph_color(kind, px, py);
                    if (px == PX_LAST) begin
                        px <= '0;
                        if (py == PX_LAST) begin
                            py <= '0;
                            if (!single_tile && !tile_last) begin
                                if (tx == TX_LAST) begin
                                    tx <= '0;
                                    ty <= ty + 1'b1;
                                end else begin
                                    tx <= tx + 1'b1;
                                end
                            end
                        end else begin
                            py <= py + 1'b1;
                        end
                    end else begin
                        px <= px + 1'b1;
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_map_tile_renderer.sv
// Self-checking bench for map_tile_renderer: a default-size instance with a
// single-cycle map memory and a small instance with three-cycle latency.
module tb_map_tile_renderer;

    localparam int GW0 = 21, GH0 = 21, P0 = 4, L0 = 1, OX0 = 0,  OY0 = 0;
    localparam int GW1 = 5,  GH1 = 4,  P1 = 2, L1 = 3, OX1 = 10, OY1 = 7;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, start_tile0 = 1'b0;
    logic [4:0] tile_x0 = '0, tile_y0 = '0, map_x0, map_y0;
    logic [3:0] map_type0;
    logic       busy0, done0, plot0;
    logic [7:0] vx0, vy0;
    logic [2:0] vc0;

    logic       start1 = 1'b0, start_tile1 = 1'b0;
    logic [4:0] tile_x1 = '0, tile_y1 = '0, map_x1, map_y1;
    logic [3:0] map_type1;
    logic       busy1, done1, plot1;
    logic [7:0] vx1, vy1;
    logic [2:0] vc1;

    map_tile_renderer #(.GRID_W(GW0), .GRID_H(GH0), .TILE_PX(P0), .X_ORIGIN(OX0),
                        .Y_ORIGIN(OY0), .MEM_LATENCY(L0), .COORD_W(5)) dut0 (
        .clock_50(clk), .resetn(resetn), .start(start0), .start_tile(start_tile0),
        .tile_x(tile_x0), .tile_y(tile_y0), .map_x(map_x0), .map_y(map_y0),
        .map_type(map_type0), .busy(busy0), .done(done0), .vga_plot(plot0),
        .vga_x(vx0), .vga_y(vy0), .vga_color(vc0));

    map_tile_renderer #(.GRID_W(GW1), .GRID_H(GH1), .TILE_PX(P1), .X_ORIGIN(OX1),
                        .Y_ORIGIN(OY1), .MEM_LATENCY(L1), .COORD_W(5)) dut1 (
        .clock_50(clk), .resetn(resetn), .start(start1), .start_tile(start_tile1),
        .tile_x(tile_x1), .tile_y(tile_y1), .map_x(map_x1), .map_y(map_y1),
        .map_type(map_type1), .busy(busy1), .done(done1), .vga_plot(plot1),
        .vga_x(vx1), .vga_y(vy1), .vga_color(vc1));

    // Map memories: dut0 reads combinationally, dut1 sees valid data only once
    // its address has been stable for two edges, random junk before that.
    logic [3:0] mem0 [0:31][0:31];
    logic [3:0] mem1 [0:31][0:31];
    logic [4:0] ax_d1, ay_d1, ax_d2, ay_d2;
    logic [3:0] junk;

    assign map_type0 = mem0[map_y0][map_x0];

    always @(posedge clk) begin
        ax_d1 <= map_x1; ay_d1 <= map_y1;
        ax_d2 <= ax_d1;  ay_d2 <= ay_d1;
        junk  <= 4'($urandom);
    end

    assign map_type1 = (ax_d1 == map_x1 && ay_d1 == map_y1 &&
                        ax_d2 == map_x1 && ay_d2 == map_y1) ? mem1[map_y1][map_x1] : junk;

    // Cycle counter and output monitors.
    typedef struct { int cyc; int x; int y; int c; } plot_t;

    int    cyc = 0;
    plot_t q0[$], q1[$];
    int    done_n0 = 0, done_c0 = 0, busy_n0 = 0;
    int    done_n1 = 0, done_c1 = 0, busy_n1 = 0;
    int    acc = 0;
    int    checks = 0, failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        plot_t p;
        if (plot0) begin
            p.cyc = cyc; p.x = int'(vx0); p.y = int'(vy0); p.c = int'(vc0);
            q0.push_back(p);
        end
        if (done0) begin done_n0++; done_c0 = cyc; end
        if (busy0) busy_n0++;
    end

    always @(negedge clk) begin
        plot_t p;
        if (plot1) begin
            p.cyc = cyc; p.x = int'(vx1); p.y = int'(vy1); p.c = int'(vc1);
            q1.push_back(p);
        end
        if (done1) begin done_n1++; done_c1 = cyc; end
        if (busy1) busy_n1++;
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference colour from the glyph rules.
    function automatic int ref_color(input int typ, input int px, input int py, input int p);
        int c;
        c = p / 2;
        case (typ)
            0: return 0;
            3: return 1;
            4: return 4;
            2: return (p <= 2 || (px == c && py == c)) ? 7 : 0;
            1: return (p <= 2 || (px >= 1 && px <= p - 2 && py >= 1 && py <= p - 2)) ? 7 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic longint pack(input plot_t v);
        return (longint'(v.cyc) << 24) | (longint'(v.x) << 16) | (longint'(v.y) << 8) | longint'(v.c);
    endfunction

    task automatic clear(input int d);
        if (d == 0) begin q0.delete(); done_n0 = 0; busy_n0 = 0; end
        else        begin q1.delete(); done_n1 = 0; busy_n1 = 0; end
    endtask

    task automatic launch(input int d, input bit s, input bit st, input int tx, input int ty);
        @(negedge clk);
        clear(d);
        if (d == 0) begin start0 = s; start_tile0 = st; tile_x0 = 5'(tx); tile_y0 = 5'(ty); end
        else        begin start1 = s; start_tile1 = st; tile_x1 = 5'(tx); tile_y1 = 5'(ty); end
        @(negedge clk);
        start0 = 1'b0; start_tile0 = 1'b0; start1 = 1'b0; start_tile1 = 1'b0;
        acc = cyc;
    endtask

    // Waits (bounded) for done; optionally pulses start / start_tile mid-frame on dut0.
    task automatic wait_done(input int d, input int budget, input int mid);
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (d == 0) begin
                start0      = (mid > 0 && i == mid);
                start_tile0 = (mid > 0 && i == mid + 100);
                tile_x0     = 5'd1;
                tile_y0     = 5'd1;
            end
            if ((d == 0 ? done_n0 : done_n1) > 0) break;
        end
        start0 = 1'b0; start_tile0 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Builds the expected plot stream from the tile walk and compares it,
    // together with done timing and busy duration.
    task automatic check_run(input int d, input bit ok, input bit full,
                             input int tx0, input int ty0, input string tag);
        plot_t e[$];
        plot_t a[$];
        plot_t v;
        int gw, p, l, ox, oy, n, per, tx, ty, typ, mism, fb, lim, dn, dc, bn;
        gw = (d == 0) ? GW0 : GW1;
        p  = (d == 0) ? P0 : P1;
        l  = (d == 0) ? L0 : L1;
        ox = (d == 0) ? OX0 : OX1;
        oy = (d == 0) ? OY0 : OY1;
        n  = !ok ? 0 : (full ? gw * ((d == 0) ? GH0 : GH1) : 1);
        per = l + p * p;
        if (d == 0) begin a = q0; dn = done_n0; dc = done_c0; bn = busy_n0; end
        else        begin a = q1; dn = done_n1; dc = done_c1; bn = busy_n1; end
        for (int t = 0; t < n; t++) begin
            tx  = full ? t % gw : tx0;
            ty  = full ? t / gw : ty0;
            typ = (d == 0) ? int'(mem0[ty][tx]) : int'(mem1[ty][tx]);
            for (int py = 0; py < p; py++)
                for (int px = 0; px < p; px++) begin
                    v.cyc = acc + t * per + l + py * p + px + 1;
                    v.x   = (ox + tx * p + px) % 256;
                    v.y   = (oy + ty * p + py) % 256;
                    v.c   = ref_color(typ, px, py, p);
                    e.push_back(v);
                end
        end
        check({tag, ".plots"}, a.size(), e.size());
        mism = 0; fb = -1;
        lim = (a.size() < e.size()) ? a.size() : e.size();
        for (int i = 0; i < lim; i++)
            if (a[i].cyc != e[i].cyc || a[i].x != e[i].x || a[i].y != e[i].y || a[i].c != e[i].c) begin
                mism++;
                if (fb < 0) fb = i;
            end
        check({tag, ".pixel_diffs"}, mism, 0);
        if (fb >= 0) check({tag, ".first_bad_pixel"}, pack(a[fb]), pack(e[fb]));
        check({tag, ".done_count"}, dn, ok ? 1 : 0);
        if (ok) check({tag, ".done_cycle"}, dc - acc, n * per + 1);
        check({tag, ".busy_cycles"}, bn, ok ? n * per + 1 : 0);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, ".busy"}, busy0, 0);
        check({tag, ".done"}, done0, 0);
        check({tag, ".plot"}, plot0, 0);
        check({tag, ".vga_x"}, vx0, 0);
        check({tag, ".vga_y"}, vy0, 0);
        check({tag, ".color"}, vc0, 0);
        check({tag, ".map_x"}, map_x0, 0);
        check({tag, ".map_y"}, map_y0, 0);
    endtask

    typedef struct { int tx; int ty; int typ; int plots; int lit;
                     int x0; int y0; int x1; int y1; int c0; int dn; } vec_t;

    initial begin
        vec_t vecs[8];
        int   cnt, nrst;

        vecs[0] = '{2,  5,  1, 16, 4, 8,  20, 11, 23, 0, 1};
        vecs[1] = '{0,  0,  2, 16, 1, 0,  0,  3,  3,  0, 1};
        vecs[2] = '{20, 20, 3, 16, 0, 80, 80, 83, 83, 1, 1};
        vecs[3] = '{21, 0,  3, 0,  0, 0,  0,  0,  0,  0, 0};
        vecs[4] = '{0,  21, 3, 0,  0, 0,  0,  0,  0,  0, 0};
        vecs[5] = '{7,  3,  4, 16, 0, 28, 12, 31, 15, 4, 1};
        vecs[6] = '{3,  3,  9, 16, 0, 12, 12, 15, 15, 0, 1};
        vecs[7] = '{31, 31, 1, 0,  0, 0,  0,  0,  0,  0, 0};

        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) begin
                mem0[y][x] = 4'd3;
                mem1[y][x] = 4'd0;
            end

        // Reset state
        repeat (3) @(negedge clk);
        check_zero0("reset");
        check("reset.busy1", busy1, 0);
        check("reset.plot1", plot1, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame, all walls
        launch(0, 1'b1, 1'b0, 0, 0);
        wait_done(0, 7600, 0);
        check_run(0, 1'b1, 1'b1, 0, 0, "wall_frame");
        if (q0.size() > 0) begin
            check("wall_frame.first_x", q0[0].x, 0);
            check("wall_frame.first_y", q0[0].y, 0);
            check("wall_frame.last_x", q0[q0.size()-1].x, 83);
            check("wall_frame.last_y", q0[q0.size()-1].y, 83);
        end
        cnt = 0;
        foreach (q0[i]) if (q0[i].c != 1) cnt++;
        check("wall_frame.non_wall_colour", cnt, 0);
        check("wall_frame.plot_total", q0.size(), 7056);

        // Single-tile table
        for (int i = 0; i < 8; i++) begin
            mem0[vecs[i].ty][vecs[i].tx] = 4'(vecs[i].typ);
            launch(0, 1'b0, 1'b1, vecs[i].tx, vecs[i].ty);
            wait_done(0, 60, 0);
            check_run(0, vecs[i].dn == 1, 1'b0, vecs[i].tx, vecs[i].ty, $sformatf("tile%0d", i));
            check($sformatf("tile%0d.tbl_plots", i), q0.size(), vecs[i].plots);
            cnt = 0;
            foreach (q0[k]) if (q0[k].c == 7) cnt++;
            check($sformatf("tile%0d.tbl_lit", i), cnt, vecs[i].lit);
            check($sformatf("tile%0d.tbl_done", i), done_n0, vecs[i].dn);
            if (q0.size() > 0) begin
                check($sformatf("tile%0d.first_x", i), q0[0].x, vecs[i].x0);
                check($sformatf("tile%0d.first_y", i), q0[0].y, vecs[i].y0);
                check($sformatf("tile%0d.first_c", i), q0[0].c, vecs[i].c0);
                check($sformatf("tile%0d.last_x", i), q0[q0.size()-1].x, vecs[i].x1);
                check($sformatf("tile%0d.last_y", i), q0[q0.size()-1].y, vecs[i].y1);
            end
        end

        // Random frame: start and start_tile together, then pulses while busy
        for (int y = 0; y < GH0; y++)
            for (int x = 0; x < GW0; x++) mem0[y][x] = 4'($urandom_range(0, 15));
        launch(0, 1'b1, 1'b1, 1, 1);
        wait_done(0, 7600, 3000);
        check_run(0, 1'b1, 1'b1, 0, 0, "rand_frame");
        repeat (30) @(negedge clk);
        check("rand_frame.single_done", done_n0, 1);

        // Three-cycle latency instance
        for (int y = 0; y < GH1; y++)
            for (int x = 0; x < GW1; x++) mem1[y][x] = 4'($urandom_range(0, 15));
        mem1[0][1] = 4'd1;
        mem1[0][2] = 4'd2;
        launch(1, 1'b1, 1'b0, 0, 0);
        wait_done(1, 400, 0);
        check_run(1, 1'b1, 1'b1, 0, 0, "lat3_frame");
        if (q1.size() > P1 * P1)
            check("lat3_frame.tile_gap", q1[P1*P1].cyc - q1[P1*P1-1].cyc, 4);
        launch(1, 1'b0, 1'b1, 1, 2);
        wait_done(1, 60, 0);
        check_run(1, 1'b1, 1'b0, 1, 2, "lat3_tile");
        launch(1, 1'b0, 1'b1, 5, 0);
        wait_done(1, 40, 0);
        check_run(1, 1'b0, 1'b0, 5, 0, "lat3_reject");

        // Reset in the middle of a frame
        for (int y = 0; y < GH0; y++)
            for (int x = 0; x < GW0; x++) mem0[y][x] = 4'($urandom_range(0, 15));
        launch(0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 1000 && q0.size() < 500; i++) @(negedge clk);
        check("rst_mid.reached_500", q0.size() >= 500, 1);
        #2 resetn = 1'b0;
        #1;
        check_zero0("rst_mid");
        nrst = q0.size();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid.no_done", done_n0, 0);
        check("rst_mid.no_plots_after", q0.size(), nrst);
        check("rst_mid.busy_low", busy0, 0);
        launch(0, 1'b1, 1'b0, 0, 0);
        wait_done(0, 7600, 0);
        check_run(0, 1'b1, 1'b1, 0, 0, "after_reset_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/map_tile_renderer.md
Name: map_tile_renderer

Overview:
Parametrised successor to the fixed 21x21 map display path. On a start request it walks the tile map and fetches each tile type from the map memory, allowing for a configurable read latency. Each tile is drawn as a TILE_PX x TILE_PX pixel block on the VGA plot interface, with orb glyphs instead of solid fills. It also supports redrawing a single tile (e.g. after Pacman eats an orb) and reports completion through a busy/done handshake.

Parameters:
GRID_W, 21, tiles per map row
GRID_H, 21, tiles per map column
TILE_PX, 4, pixel edge length of one tile (>=1)
X_ORIGIN, 0, screen x of tile (0,0) top-left pixel
Y_ORIGIN, 0, screen y of tile (0,0) top-left pixel
MEM_LATENCY, 1, cycles from map_x/map_y valid to map_type valid (>=1)
COORD_W, 5, width of tile coordinates

Ports:
clock_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  pulse: render full map (sampled only in IDLE)
start_tile  in  1  pulse: render the single tile at tile_x/tile_y (sampled only in IDLE)
tile_x  in  COORD_W  column for start_tile
tile_y  in  COORD_W  row for start_tile
map_x  out  COORD_W  map memory column address
map_y  out  COORD_W  map memory row address
map_type  in  4  tile type returned by the map memory
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse after the final pixel
vga_plot  out  1  pixel write strobe
vga_x  out  8  pixel x
vga_y  out  8  pixel y
vga_color  out  3  pixel colour

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0: map_x, map_y, busy, done, vga_plot, vga_x, vga_y, vga_color. Internal counters cleared. Reset mid-frame aborts the frame; no done pulse is produced.
- FSM states: IDLE -> FETCH -> DRAW -> (FETCH | FIN) -> IDLE.
- IDLE:
  - start=1: accept a full frame at tile (0,0).
  - start_tile=1 with tile_x<GRID_W and tile_y<GRID_H: accept a single tile at that coordinate.
  - Both start and start_tile in the same cycle: start wins.
  - start_tile with an out-of-range coordinate is ignored: no busy, no done.
  - busy rises the cycle after acceptance.
- FETCH:
  - map_x/map_y hold the current tile for exactly MEM_LATENCY cycles.
  - map_type is captured at the end of the last FETCH cycle. Go to DRAW.
- DRAW:
  - Exactly TILE_PX*TILE_PX cycles, one pixel per cycle, row-major within the tile (px fastest, then py).
  - Pixel coordinates: vga_x = X_ORIGIN + tx*TILE_PX + px and vga_y = Y_ORIGIN + ty*TILE_PX + py, truncated to 8 bits.
  - Outputs are registered: vga_plot/x/y/color for a DRAW cycle appear on the following cycle. vga_plot=0 in every other cycle.
- Tile advance after the last DRAW cycle:
  - Full frame: tx+1. If tx==GRID_W-1, then tx=0 and ty+1. If the last tile (GRID_W-1, GRID_H-1) is done, go to FIN. Otherwise go to FETCH.
  - Single tile: go straight to FIN.
- FIN: one cycle.
  - done=1 in the cycle immediately after the final vga_plot=1 cycle.
  - busy falls in the same cycle as done.
  - Return to IDLE. start/start_tile asserted while busy are dropped, not queued.
- Timing: cycles per tile = MEM_LATENCY + TILE_PX^2. Defaults give a full frame of 441*17 = 7497 DRAW/FETCH cycles.
- Colour and glyph rules (c = TILE_PX/2, integer):
  - 0 black: 000 solid.
  - 3 wall: 001 solid.
  - 4 grey: 100 solid.
  - 2 small orb: 111 only at (px,py)=(c,c), 000 elsewhere.
  - 1 big orb: 111 where 1<=px<=TILE_PX-2 and 1<=py<=TILE_PX-2, 000 elsewhere.
  - TILE_PX<=2: orbs are solid 111.
  - Types 5-15: solid 000 (defined, no latching of the previous colour).
- map_type is not sampled outside the capture cycle; changes elsewhere have no effect.

Test Plan:
- Reset then start, defaults, memory all type 3 -> 7056 vga_plot pulses, all colour 001. First pixel (0,0), last (83,83). done exactly one cycle after the last plot. busy high throughout.
- Single tile: tile (2,5)=type 1, TILE_PX=4, start_tile -> 16 plots at x 8..11, y 20..23. Colour 111 only at x 9..10, y 21..22, 000 elsewhere. Then done.
- MEM_LATENCY=3, memory returns the type 3 cycles after the address -> correct per-tile colours. Tile boundary gap of 3 cycles with vga_plot=0.
- start and start_tile(1,1) in the same cycle -> full frame runs. start pulsed mid-frame -> ignored, exactly one done.
- start_tile(21,0) -> no busy, no plots, no done.
- resetn low at pixel 500 of a frame -> all outputs 0 immediately, no done. A new start after release renders from (0,0).
